alu_74181_opseq: RTL

ALU_74181_OPSEQ -- requirements
Module: alu_74181_opseq

---
 rtl/alu_74181_pkg.sv | 26 ++
 rtl/alu_74181_logic.sv | 33 +++
 rtl/alu_74181_opseq.sv | 118 +++++++++++
 3 files changed

// File: rtl/alu_74181_pkg.sv
// Shared types and constants for the 74181 operation sequencer.
package alu_74181_pkg;

  // Sequencer states: opcode beat, operand beat, execute, hold result.
  typedef enum logic [1:0] {
    GET_OP  = 2'd0,
    GET_OPD = 2'd1,
    EXEC    = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Default width of the completed-operation counter.
  localparam int CNT_W_DEFAULT = 8;

  // Beat 0 layout: S code in the low nibble, accumulator select above it.
  localparam int S_LSB       = 0;
  localparam int S_MSB       = 3;
  localparam int USE_ACC_BIT = 4;

  // Beat 1 layout: operand A in the high nibble, operand B in the low nibble.
  localparam int A_LSB = 4;
  localparam int A_MSB = 7;
  localparam int B_LSB = 0;
  localparam int B_MSB = 3;

endpackage

// File: rtl/alu_74181_logic.sv
// Combinational 74181 logic unit (M = 1, active-high data): F as a function of S, A, B.
module alu_74181_logic (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  output logic [3:0] f
);

  // Select one of the sixteen bitwise logic functions of A and B.
  always_comb begin
    f = 4'b0000;
    unique case (s)
      4'h0: f = ~a;
      4'h1: f = ~(a | b);
      4'h2: f = ~a & b;
      4'h3: f = 4'b0000;
      4'h4: f = ~(a & b);
      4'h5: f = ~b;
      4'h6: f = a ^ b;
      4'h7: f = a & ~b;
      4'h8: f = ~a | b;
      4'h9: f = ~(a ^ b);
      4'hA: f = b;
      4'hB: f = a & b;
      4'hC: f = 4'b1111;
      4'hD: f = a | ~b;
      4'hE: f = a | b;
      4'hF: f = a;
      default: f = 4'b0000;
    endcase
  end

endmodule

// File: rtl/alu_74181_opseq.sv
// Two-beat command sequencer around the 74181 logic unit with a held,
// handshaked result, an accumulator for chaining and a consumed-result counter.
module alu_74181_opseq
  import alu_74181_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_data,
  input  logic             flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_f,
  output logic             res_zero,
  output logic             res_aeqb,
  output logic [3:0]       res_sel,
  output logic [3:0]       acc,
  output logic [CNT_W-1:0] op_cnt,
  output logic             busy
);

  state_t     state;
  state_t     state_next;
  logic [3:0] s_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic       use_acc_q;
  logic [3:0] f;
  logic       beat0_fire;
  logic       beat1_fire;
  logic       res_fire;

  alu_74181_logic u_logic (
    .a (a_q),
    .b (b_q),
    .s (s_q),
    .f (f)
  );

  // Handshake qualifiers; flush suppresses any transfer in the same cycle.
  assign beat0_fire = (state == GET_OP)  && cmd_valid && !flush;
  assign beat1_fire = (state == GET_OPD) && cmd_valid && !flush;
  assign res_fire   = (state == HOLD) && res_valid && res_ready && !flush;

  // Status outputs depend only on state and reset, never on the handshake inputs.
  assign cmd_ready = !rst && ((state == GET_OP) || (state == GET_OPD));
  assign busy      = !rst && (state != GET_OP);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= GET_OP;
    else     state <= state_next;
  end

  // Next-state decision; flush returns to the opcode beat from anywhere.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = GET_OP;
    end else begin
      unique case (state)
        GET_OP:  if (beat0_fire) state_next = GET_OPD;
        GET_OPD: if (beat1_fire) state_next = EXEC;
        EXEC:    state_next = HOLD;
        HOLD:    if (res_fire) state_next = GET_OP;
        default: state_next = GET_OP;
      endcase
    end
  end

  // Beat latches, result registers, accumulator and consumed-result counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      use_acc_q <= 1'b0;
      res_valid <= 1'b0;
      res_f     <= '0;
      res_zero  <= 1'b0;
      res_aeqb  <= 1'b0;
      res_sel   <= '0;
      acc       <= '0;
      op_cnt    <= '0;
    end else if (flush) begin
      s_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      use_acc_q <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      if (beat0_fire) begin
        s_q       <= cmd_data[S_MSB:S_LSB];
        use_acc_q <= cmd_data[USE_ACC_BIT];
      end
      if (beat1_fire) begin
        a_q <= use_acc_q ? acc : cmd_data[A_MSB:A_LSB];
        b_q <= cmd_data[B_MSB:B_LSB];
      end
      if (state == EXEC) begin
        res_f     <= f;
        res_zero  <= (f == 4'b0000);
        res_aeqb  <= (f == 4'b1111);
        res_sel   <= s_q;
        acc       <= f;
        res_valid <= 1'b1;
      end
      if (res_fire) begin
        res_valid <= 1'b0;
        op_cnt    <= op_cnt + CNT_W'(1);
      end
    end
  end

endmodule
